// File: rtl/eluks_wb_bridge_mw.sv
// eluks_wb_bridge_mw: Wishbone slave bridge in front of the ELUKS encrypted-storage core.
// It holds the password and control registers and reports status and FIFO level.
// A background fetcher streams decrypted bytes into a prefetch FIFO.
// One DATA read pops WB_DATA_WIDTH/8 of those bytes, packed little-endian.
module eluks_wb_bridge_mw #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_DIR   = 16,
  parameter int PSW_WIDTH     = 128,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                           wb_clk,
  input  logic                           wb_rst,
  input  logic [$clog2(WB_ADDR_DIR)-1:0] wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]       wb_dat_i,
  input  logic                           wb_we_i,
  input  logic                           wb_cyc_i,
  input  logic                           wb_stb_i,
  input  logic [WB_DATA_WIDTH/8-1:0]     wb_sel_i,
  output logic                           wb_ack_o,
  output logic                           wb_err_o,
  output logic                           wb_rty_o,
  output logic [WB_DATA_WIDTH-1:0]       wb_dat_o,
  output logic                           eluks_rst_o,
  output logic [PSW_WIDTH-1:0]           eluks_user_password_o,
  output logic                           eluks_hmac_enable_o,
  output logic [31:0]                    eluks_first_block_o,
  output logic [31:0]                    eluks_block_addr_o,
  output logic                           eluks_r_multi_block_o,
  output logic                           eluks_r_byte_o,
  input  logic                           eluks_busy_i,
  input  logic [7:0]                     eluks_dat_i,
  input  logic                           eluks_end_header_i,
  input  logic                           eluks_error_i,
  input  logic [31:0]                    eluks_total_blocks_i
);

  localparam int W    = WB_DATA_WIDTH;
  localparam int BPW  = WB_DATA_WIDTH / 8;
  localparam int NPSW = PSW_WIDTH / WB_DATA_WIDTH;
  localparam int AW   = $clog2(WB_ADDR_DIR);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;
  localparam int TW   = W - 1;

  // Register map: password words first, then the control and status slots.
  localparam logic [AW-1:0] ADR_FIRST  = AW'(NPSW);
  localparam logic [AW-1:0] ADR_BLOCK  = AW'(NPSW + 1);
  localparam logic [AW-1:0] ADR_HMAC   = AW'(NPSW + 2);
  localparam logic [AW-1:0] ADR_DATA   = AW'(NPSW + 3);
  localparam logic [AW-1:0] ADR_STATUS = AW'(NPSW + 4);
  localparam logic [AW-1:0] ADR_LEVEL  = AW'(NPSW + 5);

  typedef enum logic [2:0] {IDLE, WR, RD_DATA, RD_REG, ACK, ERR} bus_state_t;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_PUSH} fetch_state_t;

  bus_state_t   state_q;
  fetch_state_t fstate_q;

  logic [AW-1:0]  lat_adr_q;
  logic [W-1:0]   lat_dat_q;
  logic [BPW-1:0] lat_sel_q;

  logic [W-1:0] psw_q [NPSW];
  logic [W-1:0] first_block_q;
  logic [W-1:0] block_addr_q;
  logic [W-1:0] hmac_q;

  logic start_q;
  logic flush_d_q;
  logic wait_first_q;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;

  logic         req;
  logic         flush;
  logic         push;
  logic         pop;
  logic [W-1:0] pop_word;
  logic [W-1:0] reg_rdata;
  logic [W-1:0] status_word;
  logic [W-1:0] level_word;

  // Only the byte lanes selected by wb_sel_i take the new data.
  function automatic logic [W-1:0] merge_lanes(input logic [W-1:0] old_val,
                                               input logic [W-1:0] new_val,
                                               input logic [BPW-1:0] sel);
    logic [W-1:0] res;
    res = old_val;
    for (int b = 0; b < BPW; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  assign req   = wb_cyc_i & wb_stb_i;
  assign flush = (state_q == WR) && (lat_adr_q == ADR_BLOCK);
  assign pop   = (state_q == RD_DATA) && req && (level_q >= LW'(BPW));
  assign push  = (fstate_q == F_PUSH) && !flush;

  assign wb_rty_o              = 1'b0;
  assign eluks_rst_o           = start_q | ~eluks_end_header_i;
  assign eluks_hmac_enable_o   = hmac_q[0];
  assign status_word           = {eluks_error_i, TW'(eluks_total_blocks_i)};
  assign level_word            = W'(level_q);

  // Slot 0 drives the most significant password word.
  for (genvar g = 0; g < NPSW; g++) begin : g_psw
    assign eluks_user_password_o[PSW_WIDTH-1-g*W -: W] = psw_q[g];
  end

  if (W >= 32) begin : g_wide
    assign eluks_first_block_o = first_block_q[31:0];
    assign eluks_block_addr_o  = block_addr_q[31:0];
  end else begin : g_narrow
    assign eluks_first_block_o = {{(32-W){1'b0}}, first_block_q};
    assign eluks_block_addr_o  = {{(32-W){1'b0}}, block_addr_q};
  end

  // Gather the oldest BPW bytes of the FIFO, oldest byte in the low lane.
  always_comb begin
    pop_word = '0;
    for (int i = 0; i < BPW; i++) begin
      pop_word[i*8 +: 8] = fifo_mem[rd_ptr_q + PW'(i)];
    end
  end

  // Read mux for every readable slot except DATA.
  always_comb begin
    reg_rdata = '0;
    for (int s = 0; s < NPSW; s++) begin
      if (lat_adr_q == AW'(s)) reg_rdata = psw_q[s];
    end
    if (lat_adr_q == ADR_FIRST)  reg_rdata = first_block_q;
    if (lat_adr_q == ADR_BLOCK)  reg_rdata = block_addr_q;
    if (lat_adr_q == ADR_HMAC)   reg_rdata = hmac_q;
    if (lat_adr_q == ADR_STATUS) reg_rdata = status_word;
    if (lat_adr_q == ADR_LEVEL)  reg_rdata = level_word;
  end

  // Hold ELUKS in reset for the cycle straight after a bridge reset.
  always_ff @(posedge wb_clk) begin
    start_q <= wb_rst;
  end

  // Bus FSM: decode the request, then answer with a registered ack or err.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q   <= IDLE;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
      lat_adr_q <= '0;
      lat_dat_q <= '0;
      lat_sel_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          if (req) begin
            lat_adr_q <= wb_adr_i;
            lat_dat_q <= wb_dat_i;
            lat_sel_q <= wb_sel_i;
            if (wb_adr_i > ADR_LEVEL) begin
              state_q  <= ERR;
              wb_err_o <= 1'b1;
            end else if (wb_we_i) begin
              if (wb_adr_i < ADR_DATA) begin
                state_q <= WR;
              end else begin
                state_q  <= ERR;
                wb_err_o <= 1'b1;
              end
            end else if (wb_adr_i == ADR_DATA) begin
              state_q <= RD_DATA;
            end else begin
              state_q <= RD_REG;
            end
          end
        end
        WR: begin
          state_q  <= ACK;
          wb_ack_o <= 1'b1;
        end
        RD_REG: begin
          wb_dat_o <= reg_rdata;
          state_q  <= ACK;
          wb_ack_o <= 1'b1;
        end
        RD_DATA: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (pop) begin
            wb_dat_o <= pop_word;
            state_q  <= ACK;
            wb_ack_o <= 1'b1;
          end
        end
        ACK: begin
          if (!req) begin
            wb_ack_o <= 1'b0;
            state_q  <= IDLE;
          end
        end
        ERR: begin
          if (!req) begin
            wb_err_o <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane update of the RW registers while the bus FSM is in WR.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      for (int s = 0; s < NPSW; s++) psw_q[s] <= '0;
      first_block_q <= '0;
      block_addr_q  <= '0;
      hmac_q        <= '0;
    end else if (state_q == WR) begin
      for (int s = 0; s < NPSW; s++) begin
        if (lat_adr_q == AW'(s)) psw_q[s] <= merge_lanes(psw_q[s], lat_dat_q, lat_sel_q);
      end
      if (lat_adr_q == ADR_FIRST) first_block_q <= merge_lanes(first_block_q, lat_dat_q, lat_sel_q);
      if (lat_adr_q == ADR_BLOCK) block_addr_q  <= merge_lanes(block_addr_q, lat_dat_q, lat_sel_q);
      if (lat_adr_q == ADR_HMAC)  hmac_q        <= merge_lanes(hmac_q, lat_dat_q, lat_sel_q);
    end
  end

  // A new block address drops multi-block mode, then re-arms it one cycle later if the header is done.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      eluks_r_multi_block_o <= 1'b0;
      flush_d_q             <= 1'b0;
    end else begin
      flush_d_q <= flush;
      if (flush) begin
        eluks_r_multi_block_o <= 1'b0;
      end else if (flush_d_q && eluks_end_header_i) begin
        eluks_r_multi_block_o <= 1'b1;
      end
    end
  end

  // Fetcher FSM: one byte request at a time, only while the FIFO has room.
  always_ff @(posedge wb_clk) begin
    if (wb_rst || flush) begin
      fstate_q       <= F_IDLE;
      eluks_r_byte_o <= 1'b0;
      wait_first_q   <= 1'b0;
    end else begin
      case (fstate_q)
        F_IDLE: begin
          if (eluks_r_multi_block_o && eluks_end_header_i && !eluks_busy_i &&
              (level_q < LW'(FIFO_DEPTH))) begin
            fstate_q       <= F_REQ;
            eluks_r_byte_o <= 1'b1;
          end
        end
        F_REQ: begin
          eluks_r_byte_o <= 1'b0;
          wait_first_q   <= 1'b1;
          fstate_q       <= F_WAIT;
        end
        F_WAIT: begin
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (!eluks_busy_i) begin
            fstate_q <= F_PUSH;
          end
        end
        F_PUSH: begin
          fstate_q <= F_IDLE;
        end
        default: begin
          fstate_q       <= F_IDLE;
          eluks_r_byte_o <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and level; a push and a pop may land in the same cycle.
  always_ff @(posedge wb_clk) begin
    if (wb_rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(BPW);
      level_q <= level_q + LW'(push) - (pop ? LW'(BPW) : LW'(0));
    end
  end

  // FIFO byte storage; the level alone decides which entries are valid.
  always_ff @(posedge wb_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= eluks_dat_i;
  end

endmodule

// File: doc/eluks_wb_bridge_mw.md
Name: eluks_wb_bridge_mw

Overview:
- Next-generation Wishbone slave bridge between the SoC bus and the ELUKS encrypted-storage core.
- Generalises password width, bus width and register count over the previous bridge.
- Adds a byte-prefetch FIFO that streams decrypted bytes from ELUKS in the background; one DATA read returns WB_DATA_WIDTH/8 packed bytes.
- Adds byte-lane writes, an error response for illegal accesses, and FIFO-level reporting.

Parameters:
- WB_DATA_WIDTH, 32: bus width; multiple of 8, ≥16. BPW = WB_DATA_WIDTH/8.
- WB_ADDR_DIR, 16: number of word slots. Requires NPSW+6 ≤ WB_ADDR_DIR.
- PSW_WIDTH, 128: password width; multiple of WB_DATA_WIDTH. NPSW = PSW_WIDTH/WB_DATA_WIDTH.
- FIFO_DEPTH, 16: prefetch FIFO depth in bytes; power of 2, ≥ BPW.

Ports:
- wb_clk  in  1  clock; single clock domain.
- wb_rst  in  1  reset; synchronous, active-high.
- wb_adr_i  in  $clog2(WB_ADDR_DIR)  word address.
- wb_dat_i  in  WB_DATA_WIDTH  write data.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_sel_i  in  BPW  byte-lane select.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error response.
- wb_rty_o  out  1  constant 0.
- wb_dat_o  out  WB_DATA_WIDTH  registered read data.
- eluks_rst_o  out  1  ELUKS reset.
- eluks_user_password_o  out  PSW_WIDTH  password. Slot 0 is the MS word.
- eluks_hmac_enable_o  out  1  bit 0 of the HMAC register.
- eluks_first_block_o  out  32  first-block register, low 32 bits (zero-extended if narrower).
- eluks_block_addr_o  out  32  block-address register, same rule.
- eluks_r_multi_block_o  out  1  multi-block read enable.
- eluks_r_byte_o  out  1  one-cycle byte request.
- eluks_busy_i  in  1  ELUKS busy.
- eluks_dat_i  in  8  byte from ELUKS.
- eluks_end_header_i  in  1  header processing done.
- eluks_error_i  in  1  ELUKS error flag.
- eluks_total_blocks_i  in  32  total block count.

Behaviour:

Register map (B = NPSW):
- 0..B-1: password, RW.
- B: FIRST_BLOCK, RW.
- B+1: BLOCK_ADDR, RW.
- B+2: HMAC, RW.
- B+3: DATA, RO.
- B+4: STATUS, RO. Value = {eluks_error_i, eluks_total_blocks_i[W-2:0]}, zero-extended.
- B+5: LEVEL, RO. FIFO byte count, zero-extended.
- Addresses ≥ B+6: invalid.

Reset:
- All registers, FIFO, wb_dat_o and eluks_r_multi_block_o clear to 0.
- eluks_rst_o = 1 in the first cycle after reset (START state).
- From then on, eluks_rst_o = ~eluks_end_header_i.

Bus FSM (states IDLE, WR, RD_DATA, RD_REG, ACK, ERR); a request is wb_cyc_i & wb_stb_i:
- IDLE + request:
  - write to an RW slot → WR;
  - write to an RO slot or an invalid address → ERR;
  - read of DATA → RD_DATA;
  - read of an invalid address → ERR;
  - any other read → RD_REG.
- WR: each byte lane whose wb_sel_i bit is 1 is updated; other lanes are kept. Then → ACK.
  - A write to BLOCK_ADDR also flushes the FIFO (level = 0), clears eluks_r_multi_block_o, and clears the fetcher to F_IDLE.
  - In the cycle after that write, eluks_r_multi_block_o is set to 1 if eluks_end_header_i = 1.
- RD_REG: wb_dat_o loads the addressed value; → ACK.
- RD_DATA: wait until level ≥ BPW. Then pop BPW bytes in one cycle and load wb_dat_o little-endian (oldest byte in [7:0]); → ACK.
  - If the request drops while waiting → IDLE with no pop and no ack.
- ACK: wb_ack_o = 1 until the request drops, then → IDLE. Minimum latency: register write/read = ack 2 cycles after stb rises.
- ERR: same as ACK but drives wb_err_o instead. No register changes and no pop.
- wb_ack_o and wb_err_o are never both 1.

Fetcher FSM (F_IDLE, F_REQ, F_WAIT, F_PUSH), independent of the bus FSM:
- F_IDLE → F_REQ when eluks_r_multi_block_o = 1, eluks_end_header_i = 1, eluks_busy_i = 0 and level < FIFO_DEPTH.
- F_REQ: eluks_r_byte_o = 1 for exactly one cycle; → F_WAIT.
- F_WAIT: one mandatory cycle, then hold while eluks_busy_i = 1; → F_PUSH when busy = 0.
- F_PUSH: write eluks_dat_i into the FIFO; → F_IDLE.
- At most one request is outstanding. eluks_r_byte_o is never issued when the FIFO is full.

FIFO:
- Push and pop in the same cycle: level = level + 1 - BPW.
- Pointers wrap modulo FIFO_DEPTH.
- A flush that coincides with F_PUSH discards the byte.

Other rules:
- A wb_rst assertion mid-transaction or mid-fetch returns both FSMs to reset state in the next cycle. No ack is issued.
- eluks_error_i does not stop fetching; it is reported through STATUS only.

Test Plan:
- Reset then idle → eluks_rst_o = 1 for 1 cycle, then follows ~eluks_end_header_i; all outputs 0.
- Write 0xAABBCCDD to slot 0 with sel=0b1111, then 0x11223344 with sel=0b0101 → slot 0 = 0xAA22CC44; password[127:96] = 0xAA22CC44.
- After end_header, write BLOCK_ADDR=5 → eluks_block_addr_o = 5, multi_block = 1. Model returns bytes 0x01,0x02,0x03,0x04 with 3-cycle busy each; read DATA → wb_dat_o = 0x04030201, ack issued.
- Model fills the FIFO to 16 → no further eluks_r_byte_o; LEVEL reads 16. A DATA read drops it to 12 and fetching resumes.
- Write to STATUS, then read address 15 → wb_err_o = 1, wb_ack_o = 0, no state change. With eluks_error_i = 1 and total = 100, STATUS reads 0x80000064.
- Mid-fetch, write BLOCK_ADDR=9 → LEVEL = 0, multi_block low for 1 cycle; the in-flight byte is discarded. Separately, assert wb_rst during an RD_DATA wait → no ack, and all registers are 0 the next cycle.
